// File: rtl/mem_responder.sv
// mem_responder: single-clock behavioural memory model with independent
// instruction (read-only) and data (read/write) ports. Each port holds one
// outstanding request and answers with a one-cycle resp pulse after a fixed
// latency. resp is decoded directly from the state register and counter.
// Optional protocol checking is built only when MEM_RESPONDER_PROTO_CHECK_EN
// is defined; otherwise proto_err is tied low.
module mem_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int IMEM_LATENCY = 2,
    parameter int DMEM_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        proto_err
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] I_LOAD = 4'(IMEM_LATENCY - 1);
    localparam logic [3:0] D_LOAD = 4'(DMEM_LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        i_state, i_state_n, d_state, d_state_n;
    logic [3:0]    i_cnt, i_cnt_n, d_cnt, d_cnt_n;
    logic          i_req, d_req, i_resp, d_resp, i_acc, d_acc;
    logic [AW-1:0] i_idx, d_idx;
    logic          d_write;
    logic [3:0]    d_wmask_q;
    logic [31:0]   d_wdata_q;
    logic [31:0]   i_hold, d_hold;
    logic [31:0]   mem [DEPTH_WORDS];

    // Byte offset and bits above the store size do not select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[31:AW+2], imem_addr[1:0],
                                dmem_addr[31:AW+2], dmem_addr[1:0]};

    assign i_req  = |imem_rmask;
    assign d_req  = (|dmem_rmask) | (|dmem_wmask);
    assign i_resp = (i_state == WAIT) && (i_cnt == 4'd0);
    assign d_resp = (d_state == WAIT) && (d_cnt == 4'd0);
    // A port is free in IDLE and also in its response cycle.
    assign i_acc  = i_req && ((i_state == IDLE) || i_resp);
    assign d_acc  = d_req && ((d_state == IDLE) || d_resp);

    // State and latency counter registers for both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state <= IDLE;
            d_state <= IDLE;
            i_cnt   <= 4'd0;
            d_cnt   <= 4'd0;
        end else begin
            i_state <= i_state_n;
            d_state <= d_state_n;
            i_cnt   <= i_cnt_n;
            d_cnt   <= d_cnt_n;
        end
    end

    // Next-state logic: accept when free, count down in WAIT, leave on resp.
    always_comb begin
        i_state_n = i_state;
        i_cnt_n   = i_cnt;
        d_state_n = d_state;
        d_cnt_n   = d_cnt;
        if (i_acc) begin
            i_state_n = WAIT;
            i_cnt_n   = I_LOAD;
        end else if (i_resp) begin
            i_state_n = IDLE;
        end else if (i_state == WAIT) begin
            i_cnt_n   = i_cnt - 4'd1;
        end
        if (d_acc) begin
            d_state_n = WAIT;
            d_cnt_n   = D_LOAD;
        end else if (d_resp) begin
            d_state_n = IDLE;
        end else if (d_state == WAIT) begin
            d_cnt_n   = d_cnt - 4'd1;
        end
    end

    // Request capture on acceptance; data registers carry no reset.
    always_ff @(posedge clk) begin
        if (i_acc) begin
            i_idx <= imem_addr[2 +: AW];
        end
        if (d_acc) begin
            d_idx     <= dmem_addr[2 +: AW];
            d_write   <= |dmem_wmask;
            d_wmask_q <= dmem_wmask;
            d_wdata_q <= dmem_wdata;
        end
    end

    // Byte-masked write commit on the data response edge.
    always_ff @(posedge clk) begin
        if (d_resp && d_write) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wmask_q[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Read data is live during resp (pre-write store contents) and held after.
    assign imem_resp  = i_resp;
    assign dmem_resp  = d_resp;
    assign imem_rdata = i_resp ? mem[i_idx] : i_hold;
    assign dmem_rdata = d_resp ? (d_write ? 32'd0 : mem[d_idx]) : d_hold;

    // Hold registers keep the last returned word between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_hold <= 32'd0;
            d_hold <= 32'd0;
        end else begin
            if (i_resp) i_hold <= imem_rdata;
            if (d_resp) d_hold <= dmem_rdata;
        end
    end

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
    logic proto_hit, proto_q;

    // Violations: request while busy, read+write together, misaligned accept.
    always_comb begin
        proto_hit = 1'b0;
        if (i_req && (i_state == WAIT) && !i_resp)           proto_hit = 1'b1;
        if (d_req && (d_state == WAIT) && !d_resp)           proto_hit = 1'b1;
        if (d_acc && (|dmem_rmask) && (|dmem_wmask))         proto_hit = 1'b1;
        if (i_acc && (|imem_addr[1:0]))                      proto_hit = 1'b1;
        if (d_acc && (|dmem_addr[1:0]))                      proto_hit = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            proto_q <= 1'b0;
        else if (proto_hit) proto_q <= 1'b1;
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder with hand-computed expected values.
module tb_mem_responder;

    localparam int IL = 2;
    localparam int DL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        proto_err;

    int n_chk = 0;
    int n_err = 0;

    mem_responder #(.DEPTH_WORDS(1024), .IMEM_LATENCY(IL), .DMEM_LATENCY(DL)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(input bit is_d, output int k);
        k = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (is_d ? dmem_resp : imem_resp) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic dmem_op(input string tag, input logic [31:0] a, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] exp);
        int k;
        dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
        @(posedge clk); #1;
        dmem_rmask = '0; dmem_wmask = '0;
        wait_resp(1'b1, k);
        chk({tag, "_lat"}, k, DL);
        chk({tag, "_data"}, dmem_rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic imem_op(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int k;
        imem_addr = a; imem_rmask = 4'hF;
        @(posedge clk); #1;
        imem_rmask = '0;
        wait_resp(1'b0, k);
        chk({tag, "_lat"}, k, IL);
        chk({tag, "_data"}, imem_rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_iresp"}, imem_resp, 1'b0);
        chk({tag, "_dresp"}, dmem_resp, 1'b0);
        chk({tag, "_irdata"}, imem_rdata, 32'd0);
        chk({tag, "_drdata"}, dmem_rdata, 32'd0);
        chk({tag, "_perr"}, proto_err, 1'b0);
    endtask

    initial begin
        int seen;
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // write then instruction read of the same word, plus hold after resp
        dmem_op("wr40", 32'h40, 4'h0, 4'hF, 32'h12345678, 32'd0);
        imem_op("rd40", 32'h40, 32'h12345678);
        chk("hold_iresp", imem_resp, 1'b0);
        chk("hold_irdata", imem_rdata, 32'h12345678);

        // partial byte write over a cleared word
        dmem_op("clr0", 32'h0, 4'h0, 4'hF, 32'h0, 32'd0);
        dmem_op("part0", 32'h0, 4'h0, 4'b0101, 32'hAABBCCDD, 32'd0);
        dmem_op("rdpart", 32'h0, 4'hF, 4'h0, 32'h0, 32'h00BB00DD);

        // back-to-back instruction reads
        dmem_op("wr4", 32'h4, 4'h0, 4'hF, 32'hCAFEF00D, 32'd0);
        imem_addr = 32'h0; imem_rmask = 4'hF;
        @(posedge clk); #1;
        imem_rmask = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_resp_c%0d", k), imem_resp, (k == 2 || k == 4));
            if (k == 2) begin
                chk("b2b_data0", imem_rdata, 32'h00BB00DD);
                imem_addr = 32'h4; imem_rmask = 4'hF;
                @(posedge clk); #1;
                imem_rmask = '0;
            end
            if (k == 4) chk("b2b_data1", imem_rdata, 32'hCAFEF00D);
        end
        @(posedge clk); #1;

`ifndef MEM_RESPONDER_PROTO_CHECK_EN
        // read+write together is a write; byte offset bits are ignored
        dmem_op("rw0", 32'h0, 4'hF, 4'b0011, 32'h1234BEEF, 32'd0);
        imem_op("rdrw0", 32'h2, 32'h00BBBEEF);
`endif

        // same-cycle imem read and dmem write to word 8
        dmem_op("init8", 32'h20, 4'h0, 4'hF, 32'h5555AAAA, 32'd0);
        dmem_addr = 32'h20; dmem_wmask = 4'hF; dmem_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_wmask = '0;
        imem_addr = 32'h20; imem_rmask = 4'hF;
        @(posedge clk); #1;
        imem_rmask = '0;
        @(negedge clk);
        chk("sc_early_iresp", imem_resp, 1'b0);
        @(negedge clk);
        chk("sc_iresp", imem_resp, 1'b1);
        chk("sc_dresp", dmem_resp, 1'b1);
        chk("sc_irdata", imem_rdata, 32'h5555AAAA);
        @(posedge clk); #1;
        imem_op("sc_after", 32'h20, 32'hFFFFFFFF);

        // address wraps modulo store size
        dmem_op("wrap", 32'h1040, 4'hF, 4'h0, 32'h0, 32'h12345678);

        // reset in the middle of a pending write
        dmem_op("init80", 32'h80, 4'h0, 4'hF, 32'h11112222, 32'd0);
        dmem_addr = 32'h80; dmem_wmask = 4'hF; dmem_wdata = 32'h0BADBEEF;
        @(posedge clk); #1;
        dmem_wmask = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dmem_resp) seen++;
        end
        chk("midrst_no_dresp", seen, 0);
        @(posedge clk); #1;
        imem_op("midrst_word", 32'h80, 32'h11112222);

        // data request held into the busy period
        chk("perr_before", proto_err, 1'b0);
        dmem_addr = 32'h40; dmem_rmask = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dmem_rmask = '0;
        @(negedge clk);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("perr_set", proto_err, 1'b1);
`else
        chk("perr_set", proto_err, 1'b0);
`endif
        repeat (8) @(posedge clk);
        @(negedge clk);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("perr_sticky", proto_err, 1'b1);
`else
        chk("perr_sticky", proto_err, 1'b0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        chk("perr_rst", proto_err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
